// File: rtl/spi_master.sv
// spi_master: SPI bus master (SELECT/TRANSFER/DESELECT/GAP frame sequencer), SCLK = inner_clk/2.
// Optional macro SPI_LOOPBACK_EN adds a loopback input that captures internal mosi with cs held inactive.
module spi_master #(
  parameter int DATA_W     = 16,
  parameter int NUM_CS     = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit CS_ACTIVE  = 1'b0,
  parameter int GAP_CYCLES = 2,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              inner_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] data_tx,
  output logic [DATA_W-1:0] data_rx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic              mosi,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso,
  output logic [NUM_CS-1:0] cs
);
  localparam int CW = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] LAST = CW'(2 * DATA_W - 1);
  localparam logic [CSW:0] NCS = (CSW + 1)'(NUM_CS);
  localparam logic [NUM_CS-1:0] INACT = {NUM_CS{~CS_ACTIVE}};
  typedef enum logic [2:0] {IDLE, SELECT, TRANSFER, DESELECT, GAP} state_t;
  state_t              r_state;
  logic                r_sclk, r_mosi, r_busy, r_done, r_err;
  logic [NUM_CS-1:0]   r_cs;
  logic [DATA_W-1:0]   r_tx, r_rx, r_data_rx;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_gap;
  logic                w_lead, w_trail, w_adv, w_cap, w_in, w_bit, w_tx0, w_valid;
  logic [DATA_W-1:0]   w_sh, w_nxt, w_rx_sh;
  logic [NUM_CS-1:0]   w_cs_act;
  // Leading edge: end of SELECT and end of every odd TRANSFER cycle except the last one
  assign w_lead  = (r_state == SELECT) || (r_state == TRANSFER && r_cnt[0] && r_cnt != LAST);
  assign w_trail = (r_state == TRANSFER) && !r_cnt[0];
  assign w_adv   = CPHA ? w_lead : w_trail;
  assign w_cap   = CPHA ? w_trail : w_lead;
  assign w_sh    = LSB_FIRST ? (r_tx >> 1) : (r_tx << 1);
  assign w_nxt   = CPHA ? r_tx : w_sh;
  assign w_bit   = LSB_FIRST ? w_nxt[0] : w_nxt[DATA_W-1];
  assign w_tx0   = LSB_FIRST ? data_tx[0] : data_tx[DATA_W-1];
  assign w_valid = {1'b0, cs_sel} < NCS;
  assign w_rx_sh = LSB_FIRST ? {w_in, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], w_in};
`ifdef SPI_LOOPBACK_EN
  assign w_in     = loopback ? r_mosi : miso;
  assign w_cs_act = loopback ? INACT : INACT ^ (NUM_CS'(1) << cs_sel);
`else
  assign w_in     = miso;
  assign w_cs_act = INACT ^ (NUM_CS'(1) << cs_sel);
`endif
  always_ff @(posedge inner_clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sclk    <= CPOL;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cs      <= INACT;
      r_tx      <= '0;
      r_rx      <= '0;
      r_data_rx <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_adv) begin
        r_tx   <= w_sh;
        r_mosi <= w_bit;
      end
      if (w_cap) r_rx <= w_rx_sh;
      case (r_state)
        IDLE: begin
          if (start && w_valid) begin
            r_state <= SELECT;
            r_busy  <= 1'b1;
            r_cs    <= w_cs_act;
            r_tx    <= data_tx;
            r_mosi  <= CPHA ? 1'b0 : w_tx0;
            r_cnt   <= '0;
          end else if (start) r_err <= 1'b1;
        end
        SELECT: begin
          r_state <= TRANSFER;
          r_sclk  <= ~CPOL;
        end
        TRANSFER: begin
          r_cnt  <= r_cnt + CW'(1);
          r_sclk <= ~r_sclk;
          if (r_cnt == LAST) begin
            r_state   <= DESELECT;
            r_sclk    <= CPOL;
            r_cs      <= INACT;
            r_mosi    <= 1'b0;
            r_data_rx <= r_rx;
            r_done    <= 1'b1;
          end
        end
        DESELECT: begin
          if (GAP_CYCLES == 0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= GAP;
            r_gap   <= 4'(GAP_CYCLES - 1);
          end
        end
        GAP: begin
          if (r_gap == 4'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else r_gap <= r_gap - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign data_rx = r_data_rx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs      = r_cs;
endmodule
